ring_alarm_ctrl: RTL and testbench
==================================

RING_ALARM_CTRL -- requirements
Module: ring_alarm_ctrl

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 8, clock cycles per ring burst; legal range 2..255.
REQ-002 The block SHALL have parameter OFF_CYCLES, default 8, silent cycles after each burst; legal range 1..255.
REQ-003 The block SHALL have parameter MAX_BURSTS, default 4, bursts before auto-timeout; legal range 1..255.
REQ-004 CLK_Ring  input  1  ring clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 fin_crono  input  1  level, high while the countdown timer reports expiry.
REQ-007 ack  input  1  user silence request, level, synchronous to CLK_Ring.
REQ-008 band_parp  output  1  registered blink drive to the display/buzzer.
REQ-009 ring_active  output  1  registered, high in RING_ON or RING_OFF.
REQ-010 ring_timeout  output  1  registered one-cycle pulse on burst exhaustion.
REQ-011 burst_cnt  output  8  registered count of completed bursts in the current alarm.

Function
REQ-012 The block SHALL register fin_crono into fin_q each edge; start = fin_crono & ~fin_q (rising edge).
REQ-013 The block SHALL implement states IDLE, RING_ON, RING_OFF, DONE with an 8-bit phase counter cnt.
REQ-014 IDLE: on start with ack=0 -> RING_ON, cnt=0, band_parp=1, burst_cnt=0; on start with ack=1 -> DONE, band_parp=0; else stay.
REQ-015 RING_ON: if cnt==ON_CYCLES-1 -> RING_OFF, cnt=0, band_parp=0; else cnt+1, band_parp toggles.
REQ-016 Consequence: band_parp reads 1,0,1,0,... for exactly ON_CYCLES cycles per burst, first cycle high.
REQ-017 RING_OFF: band_parp=0; if cnt==OFF_CYCLES-1 then burst_cnt+1 and cnt=0, else cnt+1.
REQ-018 RING_OFF at cnt==OFF_CYCLES-1: if burst_cnt==MAX_BURSTS-1 -> DONE with ring_timeout=1 for that one cycle; else -> RING_ON, band_parp=1.
REQ-019 ack=1 in RING_ON or RING_OFF SHALL force DONE at the next edge, band_parp=0, no ring_timeout, burst_cnt held.
REQ-020 fin_crono=0 in RING_ON, RING_OFF or DONE SHALL force IDLE at the next edge, band_parp=0; this has priority over ack and over burst completion.
REQ-021 DONE: band_parp=0; stay until fin_crono=0, then IDLE; a new alarm requires a fresh fin_crono rising edge.
REQ-022 ring_timeout SHALL be 0 in every cycle except the single cycle after the exhausting edge.
REQ-023 burst_cnt SHALL saturate at MAX_BURSTS and never wrap.
REQ-024 ring_active SHALL be decoded from the registered state, with no combinational path from inputs.

Reset
REQ-025 On reset=1: state=IDLE, cnt=0, burst_cnt=0, band_parp=0, ring_active=0, ring_timeout=0, fin_q=1.
REQ-026 Because fin_q resets to 1, fin_crono held high through reset release SHALL NOT start an alarm.
REQ-027 Reset asserted mid-ring SHALL clear all outputs immediately, without waiting for a clock edge.

Verification
REQ-028 ON=4, OFF=2, MAX=2; fin_crono 0->1, held; ack=0 -> band_parp 1,0,1,0,0,0,1,0,1,0,0,0; ring_timeout pulses once in cycle 13; burst_cnt=2; DONE.
REQ-029 Defaults; ack=1 for one cycle at burst 1, cycle 3 -> band_parp=0 from next edge; ring_active=0; no timeout; burst_cnt=1; DONE until fin_crono=0.
REQ-030 Defaults; fin_crono falls during RING_OFF, with ack=1 on the same edge -> IDLE (not DONE); a subsequent rising edge restarts with burst_cnt=0.
REQ-031 fin_crono=1 during and after reset release -> no ring; then fin_crono 0 then 1 -> ring starts on the first edge after the rise.
REQ-032 Reset pulsed asynchronously between clock edges during RING_ON -> band_parp and ring_active are 0 before the next edge; state is IDLE.
REQ-033 MAX=1, ON=2, OFF=1: single rise -> band_parp 1,0,0; ring_timeout in cycle 4; ack and start on the same edge -> DONE, band_parp stays 0.

Source files
------------

// File: rtl/ring_alarm_ctrl.sv
// Alarm ringer: on a rising edge of the countdown-expiry level it emits blink bursts
// separated by silent gaps, until the user acknowledges, expiry clears, or bursts run out.
module ring_alarm_ctrl #(
  parameter int unsigned ON_CYCLES  = 8,
  parameter int unsigned OFF_CYCLES = 8,
  parameter int unsigned MAX_BURSTS = 4
) (
  input  logic       CLK_Ring,
  input  logic       reset,
  input  logic       fin_crono,
  input  logic       ack,
  output logic       band_parp,
  output logic       ring_active,
  output logic       ring_timeout,
  output logic [7:0] burst_cnt
);

  typedef enum logic [1:0] {IDLE, RING_ON, RING_OFF, DONE} state_t;

  localparam logic [7:0] ON_LAST  = 8'(ON_CYCLES - 1);
  localparam logic [7:0] OFF_LAST = 8'(OFF_CYCLES - 1);
  localparam logic [7:0] MAX_LAST = 8'(MAX_BURSTS - 1);
  localparam logic [7:0] MAX_N    = 8'(MAX_BURSTS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] burst_q, burst_d;
  logic       band_q, band_d;
  logic       tmo_q, tmo_d;
  logic       fin_q;
  logic       start;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == MAX_N) ? v : v + 8'd1;
  endfunction

  // fin_q powers up high so a level already present at reset release is not an edge
  assign start = fin_crono & ~fin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    band_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (ack) begin
            state_d = DONE;
          end else begin
            state_d = RING_ON;
            cnt_d   = 8'd0;
            band_d  = 1'b1;
            burst_d = 8'd0;
          end
        end
      end
      RING_ON: begin
        if (!fin_crono) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = DONE;
        end else if (cnt_q == ON_LAST) begin
          state_d = RING_OFF;
          cnt_d   = 8'd0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          band_d = ~band_q;
        end
      end
      RING_OFF: begin
        if (!fin_crono) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = DONE;
        end else if (cnt_q == OFF_LAST) begin
          cnt_d   = 8'd0;
          burst_d = sat_inc(burst_q);
          if (burst_q == MAX_LAST) begin
            state_d = DONE;
            tmo_d   = 1'b1;
          end else begin
            state_d = RING_ON;
            band_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!fin_crono) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_Ring or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      burst_q <= 8'd0;
      band_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      band_q  <= band_d;
      tmo_q   <= tmo_d;
      fin_q   <= fin_crono;
    end
  end

  assign band_parp    = band_q;
  assign ring_timeout = tmo_q;
  assign burst_cnt    = burst_q;
  assign ring_active  = (state_q == RING_ON) || (state_q == RING_OFF);

endmodule

// File: tb/tb_ring_alarm_ctrl.sv
// Directed bench for ring_alarm_ctrl: three parameterisations share one stimulus stream,
// expected outputs are queued per step and checked after the following clock edge.
module tb_ring_alarm_ctrl;

  logic       clk;
  logic       reset;
  logic       fin;
  logic       ack;
  logic [1:0] sel;

  logic       a_band, a_act, a_tmo;
  logic [7:0] a_bc;
  logic       d_band, d_act, d_tmo;
  logic [7:0] d_bc;
  logic       m_band, m_act, m_tmo;
  logic [7:0] m_bc;

  logic       obs_band, obs_act, obs_tmo;
  logic [7:0] obs_bc;

  typedef struct {
    string      tag;
    logic       band;
    logic       act;
    logic       tmo;
    logic [7:0] bc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       band_a[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] bc_a[12]   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};

  ring_alarm_ctrl #(.ON_CYCLES(4), .OFF_CYCLES(2), .MAX_BURSTS(2)) u_a (
    .CLK_Ring(clk), .reset(reset), .fin_crono(fin), .ack(ack),
    .band_parp(a_band), .ring_active(a_act), .ring_timeout(a_tmo), .burst_cnt(a_bc)
  );

  ring_alarm_ctrl u_d (
    .CLK_Ring(clk), .reset(reset), .fin_crono(fin), .ack(ack),
    .band_parp(d_band), .ring_active(d_act), .ring_timeout(d_tmo), .burst_cnt(d_bc)
  );

  ring_alarm_ctrl #(.ON_CYCLES(2), .OFF_CYCLES(1), .MAX_BURSTS(1)) u_m (
    .CLK_Ring(clk), .reset(reset), .fin_crono(fin), .ack(ack),
    .band_parp(m_band), .ring_active(m_act), .ring_timeout(m_tmo), .burst_cnt(m_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_band = a_band;
    obs_act  = a_act;
    obs_tmo  = a_tmo;
    obs_bc   = a_bc;
    case (sel)
      2'd1: begin obs_band = d_band; obs_act = d_act; obs_tmo = d_tmo; obs_bc = d_bc; end
      2'd2: begin obs_band = m_band; obs_act = m_act; obs_tmo = m_tmo; obs_bc = m_bc; end
      default: ;
    endcase
  end

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (obs_band === e.band) else begin
      n_err++;
      $error("FAIL %s band_parp got %b want %b", e.tag, obs_band, e.band);
    end
    n_cmp++;
    assert (obs_act === e.act) else begin
      n_err++;
      $error("FAIL %s ring_active got %b want %b", e.tag, obs_act, e.act);
    end
    n_cmp++;
    assert (obs_tmo === e.tmo) else begin
      n_err++;
      $error("FAIL %s ring_timeout got %b want %b", e.tag, obs_tmo, e.tmo);
    end
    n_cmp++;
    assert (obs_bc === e.bc) else begin
      n_err++;
      $error("FAIL %s burst_cnt got %0d want %0d", e.tag, obs_bc, e.bc);
    end
  endtask

  task automatic push_exp(input string tag, input logic eb, input logic ea,
                          input logic et, input logic [7:0] ebc);
    exp_t e;
    e.tag  = tag;
    e.band = eb;
    e.act  = ea;
    e.tmo  = et;
    e.bc   = ebc;
    sb.push_back(e);
  endtask

  // Drive inputs for the next edge, queue what must appear after it, then check.
  task automatic step(input logic f, input logic a, input string tag, input logic eb,
                      input logic ea, input logic et, input logic [7:0] ebc);
    fin = f;
    ack = a;
    push_exp(tag, eb, ea, et, ebc);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic chk_now(input string tag, input logic eb, input logic ea,
                         input logic et, input logic [7:0] ebc);
    push_exp(tag, eb, ea, et, ebc);
    #1;
    check_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    reset = 1'b1;
    fin   = 1'b0;
    ack   = 1'b0;
    sel   = 2'd0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      chk_now("reset_state", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ON=4 OFF=2 MAX=2: full run to timeout
    sel = 2'd0;
    step(1'b0, 1'b0, "A_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, "A_ring", band_a[i], 1'b1, 1'b0, bc_a[i]);
    step(1'b1, 1'b0, "A_timeout", 1'b0, 1'b0, 1'b1, 8'd2);
    step(1'b1, 1'b0, "A_done", 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b1, 1'b0, "A_done_hold", 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b0, "A_to_idle", 1'b0, 1'b0, 1'b0, 8'd2);

    // fin_crono high through reset release must not ring
    sel   = 2'd1;
    reset = 1'b1;
    fin   = 1'b1;
    chk_now("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, "R_high_no_ring", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, "R_low", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, "R_start", 1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, "R_on2", 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, "R_on3", 1'b1, 1'b1, 1'b0, 8'd0);

    // asynchronous reset pulse between edges mid-burst
    #2;
    reset = 1'b1;
    chk_now("rst_mid_ring", 1'b0, 1'b0, 1'b0, 8'd0);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, "R_idle_after", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, "R_idle_low", 1'b0, 1'b0, 1'b0, 8'd0);

    // defaults: ack during third cycle of the second burst
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, "D_on0", (i % 2) == 0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, "D_off0", 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, "D_on1", (i % 2) == 0, 1'b1, 1'b0, 8'd1);
    step(1'b1, 1'b1, "D_ack", 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, "D_done", 1'b0, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b0, "D_idle", 1'b0, 1'b0, 1'b0, 8'd1);

    // defaults: expiry drops in a gap together with ack -> IDLE, then clean restart
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, "F_on0", (i % 2) == 0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, "F_off0", 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, "F_on1", (i % 2) == 0, 1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, "F_off1", 1'b0, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b1, "F_fall_ack", 1'b0, 1'b0, 1'b0, 8'd1);
    step(1'b1, 1'b0, "F_restart", 1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, "F_stop", 1'b0, 1'b0, 1'b0, 8'd0);

    // MAX=1 ON=2 OFF=1: shortest alarm, then start with ack
    sel   = 2'd2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, "M_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_c1", 1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_c2", 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_c3", 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_timeout", 1'b0, 1'b0, 1'b1, 8'd1);
    step(1'b1, 1'b0, "M_done", 1'b0, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b0, "M_idle2", 1'b0, 1'b0, 1'b0, 8'd1);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, "M_idle3", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, "M_start_ack", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_done_hold", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, "M_done_hold2", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, "M_release", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
